mem_arbiter: RTL and testbench

Shares the single main-memory port between the instruction-cache and data-cache refill/writeback engines of the pipelined MIPS core. A requester holds its request until its line transfer completes; the arbiter grants one owner at a time and runs a `BEATS`-word burst on the memory port. It returns read beats or consumes write beats on the owner's side, then releases the port. It sits between the two caches and the memory model; the hazard unit keeps stalling on `hitF`/`hitM` until the corresponding `*_done` pulse.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/mem_arb_pick.sv | 34 +++
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types for the MIPS core memory-side blocks.
// Holds the arbiter state/owner enums and a beat-counter width helper.
package mips_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BURST,
    ARB_RELEASE
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_t;

  // Beat counter width: $clog2(BEATS), at least one bit.
  function automatic int beat_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selector for the I/D memory arbiter.
// Ports: i_req, d_req, last_owner in; owner out. MEM_ARB_RR_EN selects round-robin.
module mem_arb_pick
  import mips_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  arb_owner_t last_owner,
  output arb_owner_t owner
);

`ifdef MEM_ARB_RR_EN
  // A tie goes to whoever did not own the port last.
  always_comb begin
    owner = OWN_I;
    if (i_req && d_req) begin
      owner = (last_owner == OWN_D) ? OWN_I : OWN_D;
    end else if (d_req) begin
      owner = OWN_D;
    end
  end
`else
  logic unused_last;
  assign unused_last = (last_owner == OWN_D);

  always_comb begin
    owner = OWN_I;
    if (d_req) begin
      owner = OWN_D;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares the main-memory port between I-cache fills and D-cache fills/writebacks.
// Ports: clk, rst (async high); i_* / d_* cache sides; mem_* memory side.
// Define MEM_ARB_RR_EN for round-robin ties; default is D-priority.
module mem_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BEATS  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_wnext,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int BW   = beat_w(BEATS);
  localparam int STEP = DATA_W / 8;

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [BW-1:0]     beat_q, beat_d;
  arb_owner_t        grant;
  arb_owner_t        pick_last;

`ifdef MEM_ARB_RR_EN
  arb_owner_t        last_q, last_d;
  assign pick_last = last_q;
`else
  assign pick_last = OWN_I;
`endif

  mem_arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_owner (pick_last),
    .owner      (grant)
  );

  logic burst;
  logic last_beat;
  logic own_i;
  logic fin;

  assign burst     = (state_q == ARB_BURST);
  assign last_beat = (beat_q == BW'(BEATS - 1));
  assign own_i     = (owner_q == OWN_I);
  assign fin       = burst & mem_ack & last_beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_I;
      addr_q  <= '0;
      we_q    <= 1'b0;
      beat_q  <= '0;
`ifdef MEM_ARB_RR_EN
      last_q  <= OWN_I;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      beat_q  <= beat_d;
`ifdef MEM_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    we_d    = we_q;
    beat_d  = beat_q;
`ifdef MEM_ARB_RR_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      ARB_IDLE: begin
        if (i_req || d_req) begin
          owner_d = grant;
          addr_d  = (grant == OWN_D) ? d_addr : i_addr;
          we_d    = (grant == OWN_D) && d_we;
          beat_d  = '0;
          state_d = ARB_BURST;
`ifdef MEM_ARB_RR_EN
          last_d  = grant;
`endif
        end
      end
      ARB_BURST: begin
        if (mem_ack) begin
          beat_d = beat_q + 1'b1;
          if (last_beat) begin
            state_d = ARB_RELEASE;
          end
        end
      end
      ARB_RELEASE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Beat address wraps naturally in ADDR_W bits.
  assign mem_req   = burst;
  assign mem_we    = burst & we_q;
  assign mem_addr  = burst ?
                     (addr_q + (ADDR_W'(beat_q) * ADDR_W'(STEP))) :
                     '0;
  assign mem_wdata = burst ? d_wdata : '0;

  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;
  assign i_rvalid = burst & own_i & mem_ack;
  assign d_rvalid = burst & ~own_i & mem_ack & ~we_q;
  assign d_wnext  = burst & ~own_i & mem_ack & we_q;
  assign i_done   = fin & own_i;
  assign d_done   = fin & ~own_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter.
// Tie-break expectations follow MEM_ARB_RR_EN.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_wnext;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .i_done    (i_done),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_wnext   (d_wnext),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, " mem_req"},  32'(mem_req),  32'd0);
    chk({tag, " i_rvalid"}, 32'(i_rvalid), 32'd0);
    chk({tag, " d_rvalid"}, 32'(d_rvalid), 32'd0);
    chk({tag, " d_wnext"},  32'(d_wnext),  32'd0);
    chk({tag, " i_done"},   32'(i_done),   32'd0);
    chk({tag, " d_done"},   32'(d_done),   32'd0);
  endtask

  // Entered in IDLE just after a clock edge with requests already set.
  // Leaves in the following IDLE cycle with a stray ack driven.
  task automatic xfer(input string tag, input logic is_d,
                      input logic we, input logic [31:0] base,
                      input int gap, input logic rereq);
    logic        ack;
    logic [31:0] rd;
    logic [31:0] wd;
    #4;
    idle_chk({tag, "/idle"});
    tick();
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g <= gap; g++) begin
        ack       = (g == gap);
        wd        = 32'hD000_0000 + 32'(b);
        rd        = 32'hA500_0000 + 32'(b * 16 + g);
        mem_ack   = ack;
        d_wdata   = wd;
        mem_rdata = rd;
        #4;
        chk($sformatf("%s b%0d mem_req", tag, b),  32'(mem_req), 32'd1);
        chk($sformatf("%s b%0d addr", tag, b),     mem_addr,
            base + 32'(4 * b));
        chk($sformatf("%s b%0d we", tag, b),       32'(mem_we), 32'(we));
        chk($sformatf("%s b%0d wdata", tag, b),    mem_wdata, wd);
        chk($sformatf("%s b%0d i_rdata", tag, b),  i_rdata, rd);
        chk($sformatf("%s b%0d d_rdata", tag, b),  d_rdata, rd);
        chk($sformatf("%s b%0d i_rvalid", tag, b), 32'(i_rvalid),
            32'(!is_d && ack));
        chk($sformatf("%s b%0d d_rvalid", tag, b), 32'(d_rvalid),
            32'(is_d && !we && ack));
        chk($sformatf("%s b%0d d_wnext", tag, b),  32'(d_wnext),
            32'(is_d && we && ack));
        chk($sformatf("%s b%0d i_done", tag, b),   32'(i_done),
            32'(!is_d && ack && b == 3));
        chk($sformatf("%s b%0d d_done", tag, b),   32'(d_done),
            32'(is_d && ack && b == 3));
        tick();
      end
    end
    if (is_d) d_req = 1'b0;
    else      i_req = 1'b0;
    mem_ack = 1'b1;
    #4;
    idle_chk({tag, "/rel"});
    tick();
    if (rereq) begin
      if (is_d) d_req = 1'b1;
      else      i_req = 1'b1;
    end
    mem_ack = 1'b1;
  endtask

  initial begin
    rst       = 1'b1;
    i_req     = 1'b0;
    i_addr    = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = 32'h1234_5678;
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFE_0001;
    tick();
    tick();
    #4;
    idle_chk("reset");
    chk("reset mem_addr",  mem_addr,  32'd0);
    chk("reset mem_we",    32'(mem_we), 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    chk("reset i_rdata",   i_rdata,   32'hCAFE_0001);
    chk("reset d_rdata",   d_rdata,   32'hCAFE_0001);
    tick();
    rst     = 1'b0;
    mem_ack = 1'b0;

    i_req  = 1'b1;
    i_addr = 32'h0000_0100;
    xfer("ifill", 1'b0, 1'b0, 32'h0000_0100, 0, 1'b0);

    d_req  = 1'b1;
    d_we   = 1'b1;
    d_addr = 32'h0000_2000;
    xfer("dwb", 1'b1, 1'b1, 32'h0000_2000, 1, 1'b0);

    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'hFFFF_FFF8;
    xfer("wrap", 1'b1, 1'b0, 32'hFFFF_FFF8, 0, 1'b0);

    rst = 1'b1;
    #1;
    idle_chk("rst2");
    tick();
    rst    = 1'b0;
    i_addr = 32'h0000_0500;
    d_addr = 32'h0000_0600;
    d_we   = 1'b0;
    i_req  = 1'b1;
    d_req  = 1'b1;
`ifdef MEM_ARB_RR_EN
    xfer("tie0", 1'b1, 1'b0, 32'h0000_0600, 0, 1'b1);
    xfer("tie1", 1'b0, 1'b0, 32'h0000_0500, 0, 1'b1);
    xfer("tie2", 1'b1, 1'b0, 32'h0000_0600, 0, 1'b1);
    xfer("tie3", 1'b0, 1'b0, 32'h0000_0500, 0, 1'b1);
`else
    xfer("tie0", 1'b1, 1'b0, 32'h0000_0600, 0, 1'b1);
    xfer("tie1", 1'b1, 1'b0, 32'h0000_0600, 0, 1'b1);
    xfer("tie2", 1'b1, 1'b0, 32'h0000_0600, 0, 1'b1);
    xfer("tie3", 1'b1, 1'b0, 32'h0000_0600, 0, 1'b1);
`endif
    i_req = 1'b0;
    d_req = 1'b0;
    #4;
    idle_chk("tie/end");
    tick();

    mem_ack = 1'b0;
    i_req   = 1'b1;
    i_addr  = 32'h0000_0300;
    #4;
    chk("rstmid grant", 32'(mem_req), 32'd0);
    tick();
    for (int b = 0; b < 2; b++) begin
      mem_ack = 1'b1;
      #4;
      chk($sformatf("rstmid b%0d addr", b), mem_addr,
          32'h0000_0300 + 32'(4 * b));
      chk($sformatf("rstmid b%0d rvalid", b), 32'(i_rvalid), 32'd1);
      tick();
    end
    mem_ack = 1'b0;
    #2;
    chk("rstmid pre mem_req", 32'(mem_req), 32'd1);
    rst     = 1'b1;
    mem_ack = 1'b1;
    #1;
    idle_chk("rstmid async");
    chk("rstmid addr", mem_addr, 32'd0);
    i_req = 1'b0;
    tick();
    #4;
    idle_chk("rstmid hold");
    tick();
    rst     = 1'b0;
    mem_ack = 1'b0;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h0000_4000;
    xfer("postrst", 1'b1, 1'b0, 32'h0000_4000, 0, 1'b0);
    mem_ack = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
